// File: rtl/enet_boot_copier_if.sv
// Avalon-MM write-master bus used by the boot copier to push ROM words out.
interface enet_boot_copier_if;
   logic        m_write;
   logic [31:0] m_address;
   logic [31:0] m_writedata;
   logic        m_waitrequest;

   modport master (output m_write, m_address, m_writedata, input m_waitrequest);
   modport slave  (input m_write, m_address, m_writedata, output m_waitrequest);
endinterface

// File: rtl/enet_boot_copier.sv
// Copies a block of boot ROM words to an Avalon-MM destination, one word per
// ADDR/LATCH/WRITE round trip.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for start; validates the request
//   S_ADDR   | current word address presented to the registered ROM
//   S_LATCH  | ROM data valid; captured into the write-data register
//   S_WRITE  | Avalon write held until the slave drops waitrequest
//   S_FINISH | one-cycle done pulse
module enet_boot_copier #(
   parameter int ROM_WORDS      = 384,
   parameter int BYTES_PER_WORD = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       start,
   input  logic [8:0]                 start_addr,
   input  logic [9:0]                 word_count,
   input  logic [31:0]                dst_base,
   output logic [8:0]                 rom_address,
   input  logic [31:0]                rom_readdata,
   enet_boot_copier_if.master         av,
   output logic                       busy,
   output logic                       done,
   output logic                       error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_LATCH,
      S_WRITE,
      S_FINISH
   } state_t;

   localparam logic [10:0] ROM_LIMIT = 11'(ROM_WORDS);
   localparam logic [31:0] ADDR_STEP = 32'(BYTES_PER_WORD);

   state_t      state_q, state_d;
   logic [8:0]  addr_q;
   logic [9:0]  cnt_q;
   logic [31:0] maddr_q;
   logic [31:0] wdata_q;
   logic        error_q;

   logic [10:0] req_end;
   logic        req_zero;
   logic        req_bad;
   logic        req_load;
   logic        accept;
   logic        last_word;

   // Full 11-bit sum so an oversized request can never alias into range.
   assign req_end   = {2'b00, start_addr} + {1'b0, word_count};
   assign req_zero  = (word_count == 10'd0);
   assign req_bad   = !req_zero && (req_end > ROM_LIMIT);
   assign req_load  = (state_q == S_IDLE) && start && !req_zero && !req_bad;
   assign accept    = (state_q == S_WRITE) && !av.m_waitrequest;
   assign last_word = (cnt_q == 10'd1);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (req_zero)
                  state_d = S_FINISH;
               else if (!req_bad)
                  state_d = S_ADDR;
            end
         end
         S_ADDR:   state_d = S_LATCH;
         S_LATCH:  state_d = S_WRITE;
         S_WRITE: begin
            if (accept)
               state_d = last_word ? S_FINISH : S_ADDR;
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         maddr_q <= '0;
         wdata_q <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         error_q <= (state_q == S_IDLE) && start && req_bad;
         if (req_load) begin
            addr_q  <= start_addr;
            cnt_q   <= word_count;
            maddr_q <= dst_base;
         end
         if (state_q == S_LATCH)
            wdata_q <= rom_readdata;
         if (accept) begin
            cnt_q   <= cnt_q - 10'd1;
            maddr_q <= maddr_q + ADDR_STEP;
            // Holding the address on the last word keeps rom_address inside the ROM.
            if (!last_word)
               addr_q <= addr_q + 9'd1;
         end
      end
   end

   assign rom_address    = addr_q;
   assign av.m_write     = (state_q == S_WRITE);
   assign av.m_address   = maddr_q;
   assign av.m_writedata = wdata_q;
   assign busy           = (state_q != S_IDLE);
   assign done           = (state_q == S_FINISH);
   assign error          = error_q;

endmodule

// File: tb/tb_enet_boot_copier.sv
// Scoreboard bench for enet_boot_copier: expected writes are queued at start
// and retired against every accepted Avalon write.
module tb_enet_boot_copier;

   localparam int ROM_WORDS = 384;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start;
   logic [8:0]  start_addr;
   logic [9:0]  word_count;
   logic [31:0] dst_base;
   logic [8:0]  rom_address;
   logic [31:0] rom_readdata;
   logic        busy, done, error;

   enet_boot_copier_if av ();

   enet_boot_copier #(.ROM_WORDS(ROM_WORDS), .BYTES_PER_WORD(4)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .start_addr   (start_addr),
      .word_count   (word_count),
      .dst_base     (dst_base),
      .rom_address  (rom_address),
      .rom_readdata (rom_readdata),
      .av           (av),
      .busy         (busy),
      .done         (done),
      .error        (error)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;
   int  done_cnt = 0, err_cnt = 0, acc_cnt = 0, wr_cnt = 0;
   int  done_cyc = 0, err_cyc = 0;

   function automatic logic [31:0] rom_word(input logic [8:0] a);
      return {7'h5A, a, 7'h13, a ^ 9'h1FF};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Registered ROM: data for the address seen at an edge is valid the next cycle.
   always @(posedge clk) rom_readdata <= rom_word(rom_address);

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      check("rom_addr_range", 64'(rom_address < 9'(ROM_WORDS)), 1);
      if (done && error) check("done_error_excl", 1, 0);
      if (av.m_write) begin
         wr_cnt++;
         if (exp_q.size() == 0) begin
            check("sb_underflow", 1, 0);
         end else begin
            check("m_address", av.m_address, exp_q[0].addr);
            check("m_writedata", av.m_writedata, exp_q[0].data);
            if (!av.m_waitrequest) begin
               void'(exp_q.pop_front());
               acc_cnt++;
            end
         end
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (error) begin
         err_cnt++;
         err_cyc = cyc;
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rom_address"}, rom_address, 0);
      check({tag, "_m_write"}, av.m_write, 0);
      check({tag, "_m_address"}, av.m_address, 0);
      check({tag, "_m_writedata"}, av.m_writedata, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_error"}, error, 0);
   endtask

   // Entered and left at posedge+1; start is sampled at the very next edge.
   task automatic run_copy(input logic [8:0] sa, input logic [9:0] wc, input logic [31:0] base,
                           input int stall_word, input int stall_len, input bit poke);
      int  s, d0, e0, w0, a0, budget, limit, stall_used, nwords;
      bit  exp_err;
      wr_t e;
      exp_err = (wc != 0) && (({2'b00, sa} + {1'b0, wc}) > 11'(ROM_WORDS));
      nwords  = exp_err ? 0 : int'(wc);
      for (int i = 0; i < nwords; i++) begin
         e.addr = base + 32'(4 * i);
         e.data = rom_word(sa + 9'(i));
         exp_q.push_back(e);
      end
      d0 = done_cnt; e0 = err_cnt; w0 = wr_cnt; a0 = acc_cnt;
      start = 1'b1; start_addr = sa; word_count = wc; dst_base = base;
      s = cyc + 1;
      @(posedge clk); #1;
      start = 1'b0;
      start_addr = 9'($urandom); word_count = 10'($urandom); dst_base = $urandom;
      check("busy_after_start", busy, !exp_err);
      limit = 3 * nwords + stall_len + 10;
      budget = 0;
      stall_used = 0;
      while (done_cnt == d0 && err_cnt == e0 && budget < limit) begin
         av.m_waitrequest = av.m_write && (acc_cnt - a0 == stall_word) && (stall_used < stall_len);
         if (av.m_waitrequest) stall_used++;
         start = poke && (budget == 4);
         if (start) begin
            start_addr = 9'd100; word_count = 10'd2; dst_base = 32'hDEAD_0000;
         end
         @(posedge clk); #1;
         budget++;
      end
      av.m_waitrequest = 1'b0;
      start = 1'b0;
      @(posedge clk); #1;
      check("copy_timeout", 64'(budget < limit), 1);
      check("done_pulses", done_cnt - d0, exp_err ? 0 : 1);
      check("error_pulses", err_cnt - e0, exp_err ? 1 : 0);
      check("accepts", acc_cnt - a0, nwords);
      check("sb_empty", exp_q.size(), 0);
      check("idle_after", busy, 0);
      if (exp_err) begin
         check("error_cycle", err_cyc - s, 0);
         check("no_write_on_error", wr_cnt - w0, 0);
      end else begin
         check("done_cycle", done_cyc - s, 3 * nwords + stall_len);
      end
   endtask

   initial begin
      int d0, a0, budget;
      wr_t e;
      av.m_waitrequest = 1'b0;
      start = 1'b0; start_addr = '0; word_count = '0; dst_base = '0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      reset_n = 1'b1;

      run_copy(9'd0,   10'd4,   32'h0000_1000, -1, 0, 1'b0);
      run_copy(9'd380, 10'd4,   32'h0000_4000, -1, 0, 1'b0);
      run_copy(9'd381, 10'd4,   32'h0000_5000, -1, 0, 1'b0);
      run_copy(9'd0,   10'd0,   32'h0000_6000, -1, 0, 1'b0);
      run_copy(9'd20,  10'd4,   32'h0000_8000,  1, 5, 1'b0);
      run_copy(9'd50,  10'd8,   32'hFFFF_FFF0, -1, 0, 1'b1);
      run_copy(9'd383, 10'd1,   32'h0000_9000, -1, 0, 1'b0);
      run_copy(9'd511, 10'd1023, 32'h0000_A000, -1, 0, 1'b0);
      run_copy(9'd0,   10'd384, 32'h0001_0000,  7, 2, 1'b0);

      d0 = done_cnt; a0 = acc_cnt;
      start = 1'b1; start_addr = 9'd30; word_count = 10'd8; dst_base = 32'h0000_3000;
      for (int i = 0; i < 8; i++) begin
         e.addr = 32'h0000_3000 + 32'(4 * i);
         e.data = rom_word(9'd30 + 9'(i));
         exp_q.push_back(e);
      end
      @(posedge clk); #1;
      start = 1'b0;
      budget = 0;
      while (!(av.m_write && (acc_cnt - a0 == 1)) && budget < 20) begin
         @(posedge clk); #1;
         budget++;
      end
      check("rst_reach_write2", 64'(budget < 20), 1);
      #2 reset_n = 1'b0;
      #1;
      check_reset_outputs("midcopy_reset");
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1;
      check("rst_no_done", done_cnt - d0, 0);
      check("rst_accepts", acc_cnt - a0, 1);
      reset_n = 1'b1;
      run_copy(9'd10, 10'd8, 32'h0000_2000, -1, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
